// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, the default
// reset fetch address and the word stride.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_STRIDE      = 32'd4;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instruction_fetch_fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO holding {instruction, pc tag}.
// DEPTH must be a power of two so the pointers wrap naturally.
module instruction_fetch_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    assign head_data = store[rd_ptr];
    assign full      = (count == CNT_MAX);
    assign empty     = (count == '0);

    // Storage, pointers and occupancy; clear drops all entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: credit-limited prefetcher feeding an instruction queue.
// Optional macro IFETCH_PC_PLUS8_EN: ins_pc reports fetch address + 8.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(DEPTH);
`ifdef IFETCH_PC_PLUS8_EN
    localparam logic [31:0] PC_TAG_OFS = 32'd8;
`else
    localparam logic [31:0] PC_TAG_OFS = 32'd0;
`endif

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic [63:0]   q_head;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] out_left;
    logic [CW-1:0] disc_left;

    // Request credit, handshakes and the in-flight counts left after this cycle's response.
    always_comb begin
        mem_req   = (state == RUN) && !redirect && !q_full &&
                    (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_LIM);
        accept    = mem_req && mem_gnt;
        push      = (state == RUN) && mem_rvalid && !redirect;
        pop       = !q_empty && ins_ready && !redirect;
        out_left  = (mem_rvalid && outstanding != '0) ? outstanding - CNT_ONE : outstanding;
        disc_left = (mem_rvalid && discard != '0) ? discard - CNT_ONE : discard;
    end

    assign mem_addr  = fetch_pc;
    assign ins_valid = !q_empty;
    assign ins_data  = q_head[63:32];
    assign ins_pc    = q_head[31:0];

    // Responses return in order, so resp_pc simply trails fetch_pc; redirect
    // turns everything still in flight into a discard count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            fetch_pc    <= word_align(redirect_pc);
            resp_pc     <= word_align(redirect_pc);
            outstanding <= '0;
            case (state)
                IDLE: begin
                    discard <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    discard <= out_left;
                    state   <= (out_left != '0) ? FLUSH : RUN;
                end
                FLUSH: begin
                    discard <= disc_left;
                    state   <= FLUSH;
                end
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (accept) begin
                        fetch_pc <= fetch_pc + WORD_STRIDE;
                    end
                    if (push) begin
                        resp_pc <= resp_pc + WORD_STRIDE;
                    end
                    if (accept && !push) begin
                        outstanding <= outstanding + CNT_ONE;
                    end else if (!accept && push) begin
                        outstanding <= out_left;
                    end
                end
                FLUSH: begin
                    discard <= disc_left;
                    if (disc_left == '0) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    instruction_fetch_fetch_queue #(
        .DEPTH(DEPTH),
        .WIDTH(64)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect),
        .push      (push),
        .push_data ({mem_rdata, resp_pc + PC_TAG_OFS}),
        .pop       (pop),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// Bench for instruction_fetch: queue-based reference model plus a one-cycle memory.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;
`ifdef IFETCH_PC_PLUS8_EN
    localparam logic [31:0] PC_OFS = 32'd8;
`else
    localparam logic [31:0] PC_OFS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC(RST_PC),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model: delivered-word queue, in-flight address queue, discard count.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_out[$];
    int unsigned m_discard;
    int unsigned m_state;   // 0 idle, 1 running, 2 discarding
    logic [31:0] m_fpc;

    logic [31:0] g_log[$];
    int unsigned n_grants;
    logic        smp_valid;
    logic        smp_req;
    logic [31:0] smp_pc;
    logic [31:0] smp_data;

    task automatic model_reset();
        m_q.delete();
        m_out.delete();
        m_discard = 0;
        m_state   = 0;
        m_fpc     = RST_PC;
    endtask

    task automatic model_step(input logic req, input logic g, input logic r,
                              input logic rd, input logic [31:0] rpc, input logic rv);
        int unsigned inflight;
        logic [31:0] a;
        entry_t      e;
        if (rd) begin
            m_q.delete();
            inflight = m_out.size() + m_discard;
            m_out.delete();
            m_discard = (rv && inflight > 0) ? inflight - 1 : inflight;
            m_fpc = {rpc[31:2], 2'b00};
            m_state = (m_state == 2 || m_discard > 0) ? 2 : 1;
        end else begin
            if (m_q.size() > 0 && r) void'(m_q.pop_front());
            if (rv) begin
                if (m_discard > 0) m_discard--;
                else if (m_out.size() > 0) begin
                    a = m_out.pop_front();
                    e.data = mem_word(a);
                    e.pc   = a + PC_OFS;
                    m_q.push_back(e);
                end
            end
            if (req && g) begin
                m_out.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
            if (m_state == 0) m_state = 1;
            else if (m_state == 2 && m_discard == 0) m_state = 1;
        end
    endtask

    // One clock: drive inputs, compare at negedge, advance model at posedge, answer memory.
    task automatic cycle(input logic g, input logic r, input logic rd, input logic [31:0] rpc);
        logic        exp_req;
        logic        acc;
        logic [31:0] acc_addr;
        mem_gnt = g; ins_ready = r; redirect = rd; redirect_pc = rpc;
        @(negedge clk);
        exp_req = (m_state == 1) && (m_q.size() + m_out.size() < DEPTH) && !rd;
        check_eq("mem_req", mem_req, exp_req);
        check_eq("mem_addr", mem_addr, m_fpc);
        check_eq("ins_valid", ins_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check_eq("ins_data", ins_data, m_q[0].data);
            check_eq("ins_pc", ins_pc, m_q[0].pc);
        end
        if (!rst_n) begin
            check_eq("rst_ins_data", ins_data, 32'h0);
            check_eq("rst_ins_pc", ins_pc, 32'h0);
        end
        smp_valid = ins_valid; smp_req = mem_req; smp_pc = ins_pc; smp_data = ins_data;
        acc = mem_req && mem_gnt;
        acc_addr = mem_addr;
        @(posedge clk);
        if (acc) begin
            n_grants++;
            g_log.push_back(acc_addr);
        end
        if (rst_n) model_step(exp_req, g, r, rd, rpc, mem_rvalid);
        #1;
        mem_rvalid = acc && rst_n;
        mem_rdata  = acc ? mem_word(acc_addr) : 32'h0;
    endtask

    function automatic logic [31:0] glog_at(input int unsigned i);
        return (i < g_log.size()) ? g_log[i] : 32'hDEAD_BEEF;
    endfunction

    // Run n cycles with grant/ready held; return first valid pc/data seen.
    task automatic run_first(input int n, input logic r, output logic [31:0] fpc, output logic [31:0] fdat);
        logic seen;
        seen = 1'b0; fpc = 32'hDEAD_BEEF; fdat = 32'hDEAD_BEEF;
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, r, 1'b0, 32'h0);
            if (!seen && smp_valid) begin
                seen = 1'b1; fpc = smp_pc; fdat = smp_data;
            end
        end
    endtask

    initial begin
        int          first;
        logic [31:0] held;
        logic [31:0] fp;
        logic [31:0] fd;

        model_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Release with grant and ready held high.
        rst_n = 1'b1;
        g_log.delete();
        first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (first < 0 && smp_valid) first = i;
        end
        check_eq("first_valid_latency", first, 3);
        for (int unsigned i = 0; i < 4; i++) check_eq("seq_addr", glog_at(i), RST_PC + 4 * i);

        // Stalled consumer: exactly DEPTH grants, head held, then drain in order.
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        n_grants = 0;
        held = 32'h0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (i == 3) held = smp_data;
        end
        check_eq("stall_grants", n_grants, DEPTH);
        check_eq("stall_req_off", smp_req, 1'b0);
        check_eq("stall_head_held", smp_data, held);
        check_eq("stall_head_word", held, mem_word(32'h200));
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect to an unaligned target with reads in flight.
        g_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        run_first(8, 1'b1, fp, fd);
        check_eq("redir_first_addr", glog_at(0), 32'h0000_0100);
        check_eq("redir_first_pc", fp, 32'h100 + PC_OFS);
        check_eq("redir_first_data", fd, mem_word(32'h100));

        // Address wrap at the top of memory.
        g_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_a0", glog_at(0), 32'hFFFF_FFF8);
        check_eq("wrap_a1", glog_at(1), 32'hFFFF_FFFC);
        check_eq("wrap_a2", glog_at(2), 32'h0000_0000);

        // PC tag of a word fetched at 0x10.
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0010);
        run_first(6, 1'b1, fp, fd);
        check_eq("pc_tag_0x10", fp, 32'h10 + PC_OFS);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            logic        g;
            logic        r;
            logic        rd;
            logic [31:0] rpc;
            g   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
            cycle(g, r, rd, rpc);
        end

        // Reset asserted while reads are outstanding.
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        run_first(10, 1'b1, fp, fd);
        check_eq("post_reset_pc", fp, RST_PC + PC_OFS);
        check_eq("post_reset_data", fd, mem_word(RST_PC));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
